// File: rtl/ledpanel_pkg.sv
// Shared types and geometry for the 32x16 RGB LED panel datapath.
package ledpanel_pkg;

  localparam int PANEL_W     = 32;
  localparam int PANEL_H     = 16;
  localparam int PIX_PER_IMG = PANEL_W * PANEL_H;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN
  } anim_state_t;

endpackage

// File: rtl/anim_sequencer_if.sv
// Image-ROM read port plus the valid/ready pixel stream towards the panel driver.
interface anim_sequencer_if
  import ledpanel_pkg::*;
#(
  parameter int IMG_W  = 3,
  parameter int ADDR_W = 9
) ();

  logic [ADDR_W-1:0] rom_addr;
  logic [IMG_W-1:0]  rom_img;
  rgb_t              rom_rgb;
  logic              pix_valid;
  logic              pix_ready;
  rgb_t              pix_rgb;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_last;

  modport master (
    output rom_addr, rom_img, pix_valid, pix_rgb, pix_addr, pix_last,
    input  rom_rgb, pix_ready
  );

  modport slave (
    input  rom_addr, rom_img, pix_valid, pix_rgb, pix_addr, pix_last,
    output rom_rgb, pix_ready
  );

endinterface

// File: rtl/anim_img_stepper.sv
// Dwell counting and image-index stepping at refresh boundaries.
// ANIM_PINGPONG_EN selects bouncing 0..L..0 instead of wrapping 0..L,0.
module anim_img_stepper #(
  parameter int NUM_IMG = 8,
  parameter int IMG_W   = 3,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               boundary,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [IMG_W-1:0]   last_img,
  output logic [IMG_W-1:0]   cur_img,
  output logic               advance
);

  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [IMG_W-1:0]   img_q, img_d;
  logic [DWELL_W:0]   dwell_eff;
  logic [DWELL_W:0]   cnt_inc;
  logic [IMG_W-1:0]   last_clamped;

  // Extra bit keeps the +1 compare exact when dwell_cnt is at its maximum.
  assign dwell_eff    = (dwell == '0) ? (DWELL_W+1)'(1) : {1'b0, dwell};
  assign cnt_inc      = {1'b0, dwell_cnt_q} + (DWELL_W+1)'(1);
  assign advance      = boundary && (cnt_inc >= dwell_eff);
  assign last_clamped = (int'(last_img) > NUM_IMG - 1) ? IMG_W'(NUM_IMG - 1) : last_img;
  assign cur_img      = img_q;

  always_comb begin
    dwell_cnt_d = dwell_cnt_q;
    if (advance) begin
      dwell_cnt_d = '0;
    end else if (boundary) begin
      dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
    end
  end

`ifdef ANIM_PINGPONG_EN
  logic dir_down_q, dir_down_d;

  always_comb begin
    img_d      = img_q;
    dir_down_d = dir_down_q;
    if (advance) begin
      if (last_clamped == '0) begin
        img_d      = '0;
        dir_down_d = 1'b0;
      end else if (!dir_down_q) begin
        if (img_q >= last_clamped) begin
          img_d      = img_q - IMG_W'(1);
          dir_down_d = 1'b1;
        end else begin
          img_d = img_q + IMG_W'(1);
        end
      end else begin
        if (img_q == '0) begin
          img_d      = IMG_W'(1);
          dir_down_d = 1'b0;
        end else begin
          img_d = img_q - IMG_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_down_q <= 1'b0;
    end else begin
      dir_down_q <= dir_down_d;
    end
  end
`else
  always_comb begin
    img_d = img_q;
    if (advance) begin
      img_d = (img_q == last_clamped) ? '0 : img_q + IMG_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell_cnt_q <= '0;
      img_q       <= '0;
    end else begin
      dwell_cnt_q <= dwell_cnt_d;
      img_q       <= img_d;
    end
  end

endmodule

// File: rtl/anim_sequencer.sv
// Scans the 512 pixels of the current image out on a valid/ready stream and
// steps images only on refresh boundaries. ANIM_PINGPONG_EN: see anim_img_stepper.
module anim_sequencer
  import ledpanel_pkg::*;
#(
  parameter int NUM_IMG = 8,
  parameter int IMG_W   = 3,
  parameter int ADDR_W  = 9,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [IMG_W-1:0]   last_img,
  anim_sequencer_if.master   bus,
  output logic               frame_start,
  output logic [IMG_W-1:0]   cur_img
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_PER_IMG - 1);

  anim_state_t       state_q, state_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic              pix_valid_q, pix_valid_d;
  rgb_t              pix_rgb_q, pix_rgb_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              pix_last_q, pix_last_d;
  logic              frame_start_q, frame_start_d;
  logic              load;
  logic              boundary;
  logic              advance;
  logic [IMG_W-1:0]  img;

  assign load     = !pix_valid_q || bus.pix_ready;
  assign boundary = (state_q == ST_DRAIN) && pix_valid_q && bus.pix_ready && pix_last_q;

  anim_img_stepper #(
    .NUM_IMG (NUM_IMG),
    .IMG_W   (IMG_W),
    .DWELL_W (DWELL_W)
  ) u_stepper (
    .clk      (clk),
    .rst_n    (rst_n),
    .boundary (boundary),
    .dwell    (dwell),
    .last_img (last_img),
    .cur_img  (img),
    .advance  (advance)
  );

  always_comb begin
    state_d       = state_q;
    scan_addr_d   = scan_addr_q;
    pix_valid_d   = pix_valid_q;
    pix_rgb_d     = pix_rgb_q;
    pix_addr_d    = pix_addr_q;
    pix_last_d    = pix_last_q;
    frame_start_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d       = ST_SCAN;
          scan_addr_d   = '0;
          frame_start_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (load) begin
          pix_valid_d = 1'b1;
          pix_rgb_d   = bus.rom_rgb;
          pix_addr_d  = scan_addr_q;
          pix_last_d  = (scan_addr_q == LAST_ADDR);
          scan_addr_d = scan_addr_q + ADDR_W'(1);
          if (scan_addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Last pixel leaving is the only point where enable and the image may change.
        if (boundary) begin
          pix_valid_d   = 1'b0;
          scan_addr_d   = '0;
          frame_start_d = advance;
          state_d       = enable ? ST_SCAN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      scan_addr_q   <= '0;
      pix_valid_q   <= 1'b0;
      pix_rgb_q     <= '0;
      pix_addr_q    <= '0;
      pix_last_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      scan_addr_q   <= scan_addr_d;
      pix_valid_q   <= pix_valid_d;
      pix_rgb_q     <= pix_rgb_d;
      pix_addr_q    <= pix_addr_d;
      pix_last_q    <= pix_last_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.rom_addr  = scan_addr_q;
  assign bus.rom_img   = img;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_rgb   = pix_rgb_q;
  assign bus.pix_addr  = pix_addr_q;
  assign bus.pix_last  = pix_last_q;
  assign frame_start   = frame_start_q;
  assign cur_img       = img;

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer: refresh-level reference model with random
// downstream stalls; a monitor pops expected pixels as the DUT hands them over.
`timescale 1ns/1ps
module tb_anim_sequencer;
  import ledpanel_pkg::*;

  localparam int NIMG  = 8;
  localparam int NROWS = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] dwell = 16'd1;
  logic [2:0]  last_img = 3'd7;
  logic        frame_start;
  logic [2:0]  cur_img;
  logic        rand_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] img;
    logic [8:0] addr;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int d;
    int l;
    bit en;
    bit rnd;
    bit rst;
  } row_t;
  row_t plan[NROWS];

  int m_img, m_cnt, m_pos;

  anim_sequencer_if #(.IMG_W(3), .ADDR_W(9)) bus ();

  anim_sequencer #(
    .NUM_IMG (NIMG),
    .IMG_W   (3),
    .ADDR_W  (9),
    .DWELL_W (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .dwell       (dwell),
    .last_img    (last_img),
    .bus         (bus.master),
    .frame_start (frame_start),
    .cur_img     (cur_img)
  );

  initial forever #5 clk = ~clk;

  function automatic rgb_t rom_word(input logic [2:0] img, input logic [8:0] addr);
    logic [31:0] h;
    h = ({20'd0, img, addr} + 32'd1) * 32'h9E3779B1;
    h = h ^ (h >> 13);
    return rgb_t'(h[31:8]);
  endfunction

  assign bus.rom_rgb = rom_word(bus.rom_img, bus.rom_addr);

  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Refresh-level model: dwell counts refreshes; image order derived from a
  // position on the bounce path (ping-pong) or a simple modulo walk (wrap).
  function automatic bit model_boundary(input int d, input int l);
    int eff;
    int lim;
    eff = (d == 0) ? 1 : d;
    lim = (l > NIMG - 1) ? NIMG - 1 : l;
    m_cnt++;
    if (m_cnt < eff) return 1'b0;
    m_cnt = 0;
`ifdef ANIM_PINGPONG_EN
    if (lim == 0) begin
      m_pos = 0;
      m_img = 0;
    end else begin
      m_pos = (m_pos + 1) % (2 * lim);
      m_img = (m_pos <= lim) ? m_pos : 2 * lim - m_pos;
    end
`else
    m_img = (m_img == lim) ? 0 : (m_img + 1) % NIMG;
`endif
    return 1'b1;
  endfunction

  task automatic push_refresh(input int img);
    for (int a = 0; a < 512; a++) begin
      exp_t e;
      e.img  = 3'(img);
      e.addr = 9'(a);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_hs(input int addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.pix_valid && bus.pix_ready && (int'(bus.pix_addr) == addr)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_pixel_%0d actual=timeout required=handshake", addr);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_valid"},   32'(bus.pix_valid),   32'd0);
    chk({tag, "_pix_rgb"},     32'(bus.pix_rgb),     32'd0);
    chk({tag, "_pix_addr"},    32'(bus.pix_addr),    32'd0);
    chk({tag, "_pix_last"},    32'(bus.pix_last),    32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start),     32'd0);
    chk({tag, "_cur_img"},     32'(cur_img),         32'd0);
    chk({tag, "_rom_img"},     32'(bus.rom_img),     32'd0);
    chk({tag, "_rom_addr"},    32'(bus.rom_addr),    32'd0);
  endtask

  // Monitor: pops on every accepted pixel, and checks hold-stable during stalls.
  logic       prev_stall = 1'b0;
  rgb_t       prev_rgb;
  logic [8:0] prev_addr;
  logic       prev_last;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 32'(bus.pix_valid), 32'd1);
          chk("stall_rgb",   32'(bus.pix_rgb),   32'(prev_rgb));
          chk("stall_addr",  32'(bus.pix_addr),  32'(prev_addr));
          chk("stall_last",  32'(bus.pix_last),  32'(prev_last));
        end
        if (bus.pix_valid && bus.pix_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pixel actual=addr_%0d required=none", bus.pix_addr);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pix_addr", 32'(bus.pix_addr), 32'(e.addr));
            chk("pix_rgb",  32'(bus.pix_rgb),  32'(rom_word(e.img, e.addr)));
            chk("pix_last", 32'(bus.pix_last), 32'(e.addr == 9'd511));
          end
        end
        prev_stall = bus.pix_valid && !bus.pix_ready;
        prev_rgb   = bus.pix_rgb;
        prev_addr  = bus.pix_addr;
        prev_last  = bus.pix_last;
      end
    end
  end

  initial begin
    #3000000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout required=completion");
    finish_run();
  end

  initial begin : stim
    bit ok;
    bit adv;
    //        dwell last en rnd rst
    plan[0]  = '{1, 7, 1'b1, 1'b0, 1'b0};
    plan[1]  = '{1, 7, 1'b1, 1'b1, 1'b0};
    plan[2]  = '{1, 7, 1'b1, 1'b0, 1'b0};
    plan[3]  = '{0, 7, 1'b1, 1'b1, 1'b0};
    plan[4]  = '{1, 7, 1'b1, 1'b1, 1'b1};
    plan[5]  = '{1, 0, 1'b1, 1'b0, 1'b0};
    plan[6]  = '{3, 7, 1'b1, 1'b1, 1'b0};
    plan[7]  = '{3, 7, 1'b0, 1'b0, 1'b0};
    plan[8]  = '{3, 7, 1'b1, 1'b1, 1'b0};
    plan[9]  = '{1, 2, 1'b1, 1'b0, 1'b0};
    plan[10] = '{1, 2, 1'b1, 1'b1, 1'b0};
    plan[11] = '{1, 2, 1'b1, 1'b0, 1'b0};
    plan[12] = '{1, 2, 1'b1, 1'b1, 1'b0};
    plan[13] = '{1, 2, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_valid_start", 32'(bus.pix_valid), 32'd0);

    m_img = 0;
    m_cnt = 0;
    m_pos = 0;
    push_refresh(0);
    enable = 1'b1;
    @(negedge clk);
    chk("frame_start_enable", 32'(frame_start), 32'd1);
    chk("rom_addr_start", 32'(bus.rom_addr), 32'd0);

    for (int r = 0; r < NROWS; r++) begin
      rand_ready = plan[r].rnd;
      if (plan[r].rst) begin
        wait_hs(300, ok);
        if (!ok) finish_run();
        chk("img_before_reset", 32'(cur_img), 32'(m_img));
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("midscan");
        rst_n = 1'b1;
        m_img = 0;
        m_cnt = 0;
        m_pos = 0;
        push_refresh(0);
        @(negedge clk);
        chk("frame_start_after_reset", 32'(frame_start), 32'd1);
        chk("rom_img_after_reset", 32'(bus.rom_img), 32'd0);
        $display("refresh %0d: reset at addr 300 -> restart img=0", r);
        continue;
      end
      wait_hs(100, ok);
      if (!ok) finish_run();
      dwell    = 16'(plan[r].d);
      last_img = 3'(plan[r].l);
      enable   = plan[r].en;
      wait_hs(511, ok);
      if (!ok) finish_run();
      adv = model_boundary(plan[r].d, plan[r].l);
      @(negedge clk);
      chk("frame_start_boundary", 32'(frame_start), 32'(adv));
      chk("cur_img_boundary", 32'(cur_img), 32'(m_img));
      $display("refresh %0d: dwell=%0d last=%0d en=%0b rnd=%0b -> img=%0d advance=%0b",
               r, plan[r].d, plan[r].l, plan[r].en, plan[r].rnd, m_img, adv);
      if (plan[r].en) begin
        push_refresh(m_img);
        @(negedge clk);
        chk("frame_start_pulse_end", 32'(frame_start), 32'd0);
      end else begin
        repeat (3) @(negedge clk);
        chk("idle_valid", 32'(bus.pix_valid), 32'd0);
        chk("idle_img", 32'(cur_img), 32'(m_img));
        if (r != NROWS - 1) begin
          push_refresh(m_img);
          enable = 1'b1;
          @(negedge clk);
          chk("frame_start_resume", 32'(frame_start), 32'd1);
          chk("resume_img", 32'(cur_img), 32'(m_img));
        end
      end
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_valid", 32'(bus.pix_valid), 32'd0);
    finish_run();
  end

endmodule

// File: doc/anim_sequencer.md
# anim_sequencer

Frame sequencer for the 8-image, 32x16 RGB panel image ROM. Scans the 512 pixel addresses of the current image, presents each pixel on a valid/ready stream to the panel driver, and steps the image index after a programmable number of complete refreshes. Sits between the image ROM (combinational read, `{img,addr}` indexed) and the row/column shift-out logic. Image changes happen only on refresh boundaries, so the panel never shows a torn frame.

## Interface
- `NUM_IMG`, 8: images stored in ROM.
- `IMG_W`, 3: image index width.
- `ADDR_W`, 9: pixel address width (512 pixels per image).
- `DWELL_W`, 16: dwell counter width.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  run animation; sampled only at refresh boundaries.
- `dwell`  in  DWELL_W  refreshes per image; 0 treated as 1.
- `last_img`  in  IMG_W  highest image index used; values >= NUM_IMG clamp to NUM_IMG-1.
- `rom_addr`  out  ADDR_W  pixel address to ROM.
- `rom_img`  out  IMG_W  image index to ROM.
- `rom_rgb`  in  24  ROM pixel data, valid same cycle as address.
- `pix_valid`  out  1  output pixel valid.
- `pix_ready`  in  1  downstream accepts pixel.
- `pix_rgb`  out  24  pixel data.
- `pix_addr`  out  ADDR_W  address of presented pixel.
- `pix_last`  out  1  presented pixel is address 511.
- `frame_start`  out  1  one-cycle pulse when a new image is selected.
- `cur_img`  out  IMG_W  image being scanned (equals `rom_img`).

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: `pix_valid`=0; when `enable`=1 go SCAN, `scan_addr`=0, pulse `frame_start`.
- SCAN: output register loads when `!pix_valid || pix_ready`; load captures `rom_rgb`, `scan_addr`, sets `pix_last`=(`scan_addr`==511), then `scan_addr`++. After loading address 511 go DRAIN.
- DRAIN: wait until pixel 511 accepted (`pix_valid && pix_ready && pix_last`). Then refresh boundary:
  - `dwell_cnt`++; if `dwell_cnt`+1 >= max(`dwell`,1): `dwell_cnt`=0, advance image, pulse `frame_start` next cycle.
  - Advance: `cur_img`==clamped `last_img` -> 0, else +1.
  - `enable`=1 -> SCAN with `scan_addr`=0; else IDLE (image index and `dwell_cnt` retained).
- `dwell`/`last_img` changes take effect at next refresh boundary comparison; no mid-refresh effect.
- `pix_valid` never drops while `pix_ready`=0; `pix_rgb`/`pix_addr`/`pix_last` stable while stalled.

## Timing
- Reset values: `pix_valid`=0, `pix_rgb`=0, `pix_addr`=0, `pix_last`=0, `frame_start`=0, `cur_img`=0, `rom_img`=0, `rom_addr`=0; state IDLE, `dwell_cnt`=0.
- Latency: `rom_addr` presented in cycle N -> `pix_rgb` valid cycle N+1.
- Throughput: 1 pixel/cycle with `pix_ready` held high; refresh = 512 transfers + 1 boundary cycle (DRAIN->SCAN).
- `frame_start` asserts the cycle `scan_addr`=0 of a new image is first driven on `rom_addr`.
- Reset mid-scan: all state returns to reset values in the cycle after `rst_n` sampled low; no partial pixel emitted.

## Configuration
- `ANIM_PINGPONG_EN` defined: image index runs 0..last_img..0 (direction bit flips at endpoints, endpoints shown once per pass: 0,1,..,L,L-1,..,1,0,1..). `last_img`=0 holds image 0.
- Undefined: wrap 0..last_img, 0..; no direction state synthesised.

## Structure
- Shared package `ledpanel_pkg`: `PANEL_W`=32, `PANEL_H`=16, `PIX_PER_IMG`=512, `rgb_t` (24-bit packed r/g/b), `anim_state_t` enum.
- Sub-module `anim_img_stepper`: owns `dwell_cnt`, image index, clamping, ping-pong direction; inputs `boundary` strobe, `dwell`, `last_img`; outputs `cur_img`, `advance`.

## Test plan
- Reset, `enable`=1, `dwell`=1, `last_img`=7, `pix_ready`=1 -> 512 pixels img 0 addr 0..511, `pix_last` only on 511, then `frame_start`, img 1.
- `dwell`=3 -> img 0 scanned 3 refreshes, img advances on 3rd boundary; `dwell`=0 behaves as 1.
- `last_img`=2 -> sequence 0,1,2,0; with `ANIM_PINGPONG_EN` -> 0,1,2,1,0,1.
- `pix_ready` random 50% -> every address 0..511 appears exactly once, in order, data matches ROM[{img,addr}], outputs stable during stall.
- `enable` dropped at addr 100 -> scan completes through 511, then IDLE, `pix_valid`=0; re-enable resumes same img/dwell count.
- `rst_n`=0 at addr 300 of img 4 -> next cycle all outputs at reset values, restart img 0 addr 0.
